// File: rtl/player1_recorder.sv
`timescale 1ns/1ps
// player1_recorder
// Purpose: captures player 1's secret code from a push-button as a
// Morse-style bit pattern on the slow tick clock.
//   - A short press (fewer than LONG_TICKS ticks) appends a dot, 2'b10.
//   - A long press appends a dash, 4'b1110.
//   - Pressing finish locks the code so player2 can compare against it.
// Ports:
//   clock         tick clock from rate_divider; all logic on posedge
//   resetn        asynchronous active-low reset
//   value_input   symbol key, active-low (0 = pressed)
//   finish_input  finish key, active-low (0 = pressed)
//   player1_value recorded code, right-aligned, newest symbol in LSBs
//   length        number of code bits in use, 0..WIDTH
//   done          code is locked and valid for player2
//   overflow      sticky flag: a symbol was dropped for lack of space
//   q             LED view of player1_value[17:0]
module player1_recorder #(
    parameter int WIDTH      = 20,
    parameter int LONG_TICKS = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             value_input,
    input  logic             finish_input,
    output logic [WIDTH-1:0] player1_value,
    output logic [4:0]       length,
    output logic             done,
    output logic             overflow,
    output logic [17:0]      q
);

    localparam int CW = $clog2(LONG_TICKS + 1);

    typedef enum logic {
        RECORD = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   hold_count;
    logic            prev_key;

    logic            release_seen;
    logic            is_dash;
    logic [5:0]      sym_len;
    logic [5:0]      len_sum;
    logic            commit;
    logic            drop;
    logic [4:0]      len_after;
    logic            finish_ok;
    logic [WIDTH-1:0] value_next;

    // Release and commit decode. The finish decision uses the length as it
    // will be after any commit on this same tick, so a release and a finish
    // sampled together both take effect.
    always_comb begin
        release_seen = 1'b0;
        is_dash      = 1'b0;
        sym_len      = 6'd2;
        len_sum      = 6'd0;
        commit       = 1'b0;
        drop         = 1'b0;
        len_after    = length;
        finish_ok    = 1'b0;
        value_next   = player1_value;

        release_seen = (state == RECORD) && !prev_key && value_input;
        is_dash      = (hold_count >= CW'(LONG_TICKS));
        sym_len      = is_dash ? 6'd4 : 6'd2;
        len_sum      = {1'b0, length} + sym_len;
        commit       = release_seen && (len_sum <= 6'(WIDTH));
        drop         = release_seen && (len_sum > 6'(WIDTH));

        if (commit) begin
            len_after = len_sum[4:0];
        end

        if (is_dash) begin
            value_next = {player1_value[WIDTH-5:0], 4'b1110};
        end else begin
            value_next = {player1_value[WIDTH-3:0], 2'b10};
        end

        // A finish while the symbol key is still down is ignored.
        finish_ok = (state == RECORD) && !finish_input && value_input &&
                    (len_after != 5'd0);
    end

    // Recorder state machine. prev_key resets to "released" so a press that
    // straddles the end of reset counts from its first sampled tick and does
    // not produce a spurious commit.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= RECORD;
            hold_count    <= '0;
            prev_key      <= 1'b1;
            player1_value <= '0;
            length        <= 5'd0;
            done          <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            case (state)
                RECORD: begin
                    prev_key <= value_input;

                    if (!value_input) begin
                        if (hold_count != CW'(LONG_TICKS)) begin
                            hold_count <= hold_count + 1'b1;
                        end
                    end else begin
                        hold_count <= '0;
                    end

                    if (commit) begin
                        player1_value <= value_next;
                        length        <= len_after;
                    end

                    if (drop) begin
                        overflow <= 1'b1;
                    end

                    if (finish_ok) begin
                        state <= LOCKED;
                        done  <= 1'b1;
                    end
                end

                LOCKED: begin
                    done <= 1'b1;
                end

                default: begin
                    state <= RECORD;
                end
            endcase
        end
    end

    assign q = player1_value[17:0];

endmodule

// File: tb/tb_player1_recorder.sv
`timescale 1ns/1ps
// tb_player1_recorder
// Purpose: self-checking bench for player1_recorder. A reference model
// tracks whole press durations and the code as an integer, pushes the
// expected outputs for every tick into a scoreboard queue, and a separate
// monitor pops and compares on each falling edge. Directed test-plan
// sequences are followed by randomized press/finish traffic.
module tb_player1_recorder;

    localparam int WIDTH      = 20;
    localparam int LONG_TICKS = 3;

    logic             clock;
    logic             resetn;
    logic             value_input;
    logic             finish_input;
    logic [WIDTH-1:0] player1_value;
    logic [4:0]       length;
    logic             done;
    logic             overflow;
    logic [17:0]      q;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [WIDTH-1:0] val;
        logic [4:0]       len;
        logic             done;
        logic             ovf;
    } exp_t;

    exp_t sb[$];

    // Reference model state.
    logic [WIDTH-1:0] m_val;
    int               m_len;
    bit               m_done;
    bit               m_ovf;
    int               m_dur;
    bit               m_was_pressed;

    player1_recorder #(
        .WIDTH      (WIDTH),
        .LONG_TICKS (LONG_TICKS)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .value_input   (value_input),
        .finish_input  (finish_input),
        .player1_value (player1_value),
        .length        (length),
        .done          (done),
        .overflow      (overflow),
        .q             (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic void resetModel();
        m_val         = '0;
        m_len         = 0;
        m_done        = 1'b0;
        m_ovf         = 1'b0;
        m_dur         = 0;
        m_was_pressed = 1'b0;
    endfunction

    // Model of one tick: presses are measured as whole durations; on
    // release the symbol is chosen from the duration and appended if it fits.
    function automatic void stepModel(input bit v, input bit f);
        int n;
        int pat;
        if (m_done) return;
        if (m_was_pressed && v) begin
            if (m_dur >= LONG_TICKS) begin
                n = 4; pat = 14;
            end else begin
                n = 2; pat = 2;
            end
            if (m_len + n <= WIDTH) begin
                m_val = WIDTH'(m_val * (1 << n) + pat);
                m_len = m_len + n;
            end else begin
                m_ovf = 1'b1;
            end
            m_dur = 0;
        end
        if (!v) m_dur++;
        if (!f && v && m_len > 0) m_done = 1'b1;
        m_was_pressed = !v;
    endfunction

    // Drives one tick of inputs; called just after a falling edge and
    // returns just after the next falling edge.
    task automatic applyStimulus(input bit v, input bit f);
        exp_t e;
        value_input  = v;
        finish_input = f;
        @(posedge clock);
        stepModel(v, f);
        e.val  = m_val;
        e.len  = 5'(m_len);
        e.done = m_done;
        e.ovf  = m_ovf;
        sb.push_back(e);
        @(negedge clock);
        #1;
    endtask

    task automatic expectState(input string name, input logic [WIDTH-1:0] val,
                               input int len, input bit d, input bit ovf);
        checkOutput({name, "_value"},    32'(player1_value), 32'(val));
        checkOutput({name, "_length"},   32'(length),        32'(len));
        checkOutput({name, "_done"},     32'(done),          32'(d));
        checkOutput({name, "_overflow"}, 32'(overflow),      32'(ovf));
        checkOutput({name, "_q"},        32'(q),             32'(val[17:0]));
    endtask

    // Asserts reset away from any clock edge, checks outputs clear at once,
    // and releases it a few ns after a rising edge.
    task automatic doReset(input string name);
        #2;
        resetn = 1'b0;
        #1;
        expectState({name, "_async"}, '0, 0, 1'b0, 1'b0);
        @(posedge clock);
        #3;
        resetModel();
        resetn = 1'b1;
        @(negedge clock);
        #1;
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("sb_value",    32'(player1_value), 32'(e.val));
                checkOutput("sb_length",   32'(length),        32'(e.len));
                checkOutput("sb_done",     32'(done),          32'(e.done));
                checkOutput("sb_overflow", 32'(overflow),      32'(e.ovf));
                checkOutput("sb_q",        32'(q),             32'(e.val[17:0]));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int left;
        bit v;
        bit f;
        resetn       = 1'b0;
        value_input  = 1'b1;
        finish_input = 1'b1;
        resetModel();
        @(negedge clock);
        #1;

        // Dot, dash, finish.
        doReset("t1");
        applyStimulus(0, 1);
        applyStimulus(1, 1);
        repeat (3) applyStimulus(0, 1);
        applyStimulus(1, 1);
        applyStimulus(1, 0);
        expectState("t1", 20'b101110, 6, 1'b1, 1'b0);

        // Saturating hold counter gives a single dash.
        doReset("t2");
        repeat (5) applyStimulus(0, 1);
        applyStimulus(1, 1);
        expectState("t2", 20'b1110, 4, 1'b0, 1'b0);

        // Fill to capacity, then overflow.
        doReset("t3");
        repeat (5) begin
            repeat (3) applyStimulus(0, 1);
            applyStimulus(1, 1);
        end
        applyStimulus(0, 1);
        applyStimulus(1, 1);
        expectState("t3_full", 20'hEEEEE, 20, 1'b0, 1'b1);
        applyStimulus(0, 1);
        applyStimulus(1, 1);
        expectState("t3_drop2", 20'hEEEEE, 20, 1'b0, 1'b1);
        applyStimulus(1, 0);
        expectState("t3_lock", 20'hEEEEE, 20, 1'b1, 1'b1);

        // Finish ignored when empty or while pressed; release+finish locks.
        doReset("t4");
        applyStimulus(1, 0);
        expectState("t4_empty", '0, 0, 1'b0, 1'b0);
        applyStimulus(0, 0);
        expectState("t4_held", '0, 0, 1'b0, 1'b0);
        applyStimulus(1, 0);
        expectState("t4_same", 20'b10, 2, 1'b1, 1'b0);

        // Inputs ignored while locked.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(bit'(i % 2), bit'((i / 2) % 2));
        end
        expectState("t5_locked", 20'b10, 2, 1'b1, 1'b0);

        // Reset mid-LOCKED, then mid-press; the counter restarts cleanly.
        doReset("t6_locked");
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        doReset("t6_press");
        applyStimulus(0, 1);
        applyStimulus(1, 1);
        expectState("t6", 20'b10, 2, 1'b0, 1'b0);

        // Randomized press/finish traffic.
        for (int r = 0; r < 15; r++) begin
            doReset("rnd");
            left = 0;
            for (int t = 0; t < 40; t++) begin
                if (left > 0) begin
                    v = 1'b0;
                    left--;
                end else if ($urandom_range(0, 2) == 0) begin
                    v = 1'b0;
                    left = int'($urandom_range(1, 5)) - 1;
                end else begin
                    v = 1'b1;
                end
                f = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
                applyStimulus(v, f);
            end
        end

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain actual=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
